adpll_loop_filter: RTL and testbench

Digital proportional-integral loop filter for the ADPLL, sitting between the phase/frequency detector (upstream, supplies signed phase-error samples) and the digitally controlled oscillator (downstream, consumes an unsigned tuning word). Each accepted error sample updates a saturating integrator and produces a clamped control word two cycles later. The block also reports clamp status and a lock indication based on consecutive small-error samples.

---
 rtl/adpll_loop_filter.sv | 142 ++++++++++++++
 tb/tb_adpll_loop_filter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/adpll_loop_filter.sv
// adpll_loop_filter
//   Proportional-integral loop filter between the phase/frequency detector and
//   the DCO. Each accepted phase-error sample updates a saturating integrator
//   (stage 1). One edge later the proportional and integral terms are summed
//   onto the tuning-word offset and clamped to the DCO range (stage 2). A lock
//   detector counts consecutive small-error samples.
//
// Ports
//   clk        : single rising-edge clock
//   rst        : synchronous active-high reset
//   err_valid  : phase-error sample strobe
//   err        : signed phase error (ERR_W bits)
//   hold       : when high, incoming samples are dropped
//   ctrl_out   : unsigned DCO tuning word (CTRL_W bits)
//   ctrl_valid : one-cycle pulse when ctrl_out updates
//   sat_hi     : last tuning word was clamped at full scale
//   sat_lo     : last tuning word was clamped at zero
//   locked     : lock indication
module adpll_loop_filter #(
    parameter int ERR_W     = 8,
    parameter int CTRL_W    = 8,
    parameter int ACC_W     = 16,
    parameter int KP_SHIFT  = 1,
    parameter int KI_SHIFT  = 4,
    parameter int CTRL_INIT = 128,
    parameter int LOCK_TOL  = 2,
    parameter int LOCK_CNT  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              err_valid,
    input  logic [ERR_W-1:0]  err,
    input  logic              hold,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic              ctrl_valid,
    output logic              sat_hi,
    output logic              sat_lo,
    output logic              locked
);

    localparam int SUM_W = ACC_W + 2;
    localparam int LCW   = $clog2(LOCK_CNT + 1);

    logic signed [ACC_W-1:0] integ;
    logic signed [ERR_W-1:0] err_d;
    logic                    stage1_valid;
    logic [LCW-1:0]          lock_cnt;

    logic                    accept;
    logic signed [ACC_W:0]   integ_wide;
    logic signed [ACC_W-1:0] integ_next;
    logic                    windup_block;

    logic signed [ERR_W-1:0] p_term;
    logic signed [ACC_W-1:0] i_term;
    logic signed [SUM_W-1:0] sum;
    logic                    sum_hi;
    logic                    sum_lo;
    logic [CTRL_W-1:0]       ctrl_clamped;

    logic signed [ERR_W:0]   err_x;
    logic [ERR_W:0]          err_abs;
    logic [LCW-1:0]          lock_cnt_next;

    assign accept = err_valid && !hold;

    // Stage 1: saturating integrator with anti-windup against the registered
    // clamp flags.
    always_comb begin
        integ_wide = {integ[ACC_W-1], integ} +
                     {{(ACC_W + 1 - ERR_W){err[ERR_W-1]}}, err};
        if (integ_wide[ACC_W] != integ_wide[ACC_W-1]) begin
            integ_next = integ_wide[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}}
                                           : {1'b0, {(ACC_W - 1){1'b1}}};
        end else begin
            integ_next = integ_wide[ACC_W-1:0];
        end
        windup_block = (sat_hi && !err[ERR_W-1] && (err != '0)) ||
                       (sat_lo && err[ERR_W-1]);
    end

    // Stage 2: P + I + offset at ACC_W+2 bits so no intermediate can overflow.
    always_comb begin
        p_term = err_d >>> KP_SHIFT;
        i_term = integ >>> KI_SHIFT;
        sum    = SUM_W'(CTRL_INIT) +
                 {{(SUM_W - ERR_W){p_term[ERR_W-1]}}, p_term} +
                 {{(SUM_W - ACC_W){i_term[ACC_W-1]}}, i_term};
        sum_lo = sum[SUM_W-1];
        sum_hi = !sum_lo && (sum > SUM_W'((1 << CTRL_W) - 1));
        if (sum_lo) begin
            ctrl_clamped = '0;
        end else if (sum_hi) begin
            ctrl_clamped = '1;
        end else begin
            ctrl_clamped = sum[CTRL_W-1:0];
        end
    end

    // Lock detector: |err| one bit wider so the most negative code stays large.
    always_comb begin
        err_x   = {err[ERR_W-1], err};
        err_abs = err_x[ERR_W] ? $unsigned(-err_x) : $unsigned(err_x);
        if (err_abs <= (ERR_W + 1)'(LOCK_TOL)) begin
            lock_cnt_next = (lock_cnt == LCW'(LOCK_CNT)) ? lock_cnt
                                                         : lock_cnt + LCW'(1);
        end else begin
            lock_cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            integ        <= '0;
            err_d        <= '0;
            stage1_valid <= 1'b0;
            lock_cnt     <= '0;
            ctrl_out     <= CTRL_W'(CTRL_INIT);
            ctrl_valid   <= 1'b0;
            sat_hi       <= 1'b0;
            sat_lo       <= 1'b0;
            locked       <= 1'b0;
        end else begin
            stage1_valid <= accept;
            ctrl_valid   <= stage1_valid;
            locked       <= (lock_cnt == LCW'(LOCK_CNT));
            if (stage1_valid) begin
                ctrl_out <= ctrl_clamped;
                sat_hi   <= sum_hi;
                sat_lo   <= sum_lo;
            end
            if (accept) begin
                err_d    <= err;
                lock_cnt <= lock_cnt_next;
                if (!windup_block) begin
                    integ <= integ_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_adpll_loop_filter.sv
// Self-checking bench for adpll_loop_filter: a plain-integer reference model
// tracked on every clock edge, plus literal expectations at key points.
module tb_adpll_loop_filter;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              err_valid = 1'b0;
    logic signed [7:0] err = '0;
    logic              hold = 1'b0;
    logic [7:0]        ctrl_out;
    logic              ctrl_valid;
    logic              sat_hi;
    logic              sat_lo;
    logic              locked;

    int errors = 0;
    int checks = 0;
    int cv_count = 0;

    adpll_loop_filter #(
        .ERR_W(8), .CTRL_W(8), .ACC_W(16), .KP_SHIFT(1), .KI_SHIFT(4),
        .CTRL_INIT(128), .LOCK_TOL(2), .LOCK_CNT(16)
    ) dut (
        .clk(clk), .rst(rst), .err_valid(err_valid), .err(err), .hold(hold),
        .ctrl_out(ctrl_out), .ctrl_valid(ctrl_valid), .sat_hi(sat_hi),
        .sat_lo(sat_lo), .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int fdiv(input int a, input int b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    // Reference model state
    int m_integ = 0, m_ctrl = 128, m_cnt = 0;
    bit m_shi = 0, m_slo = 0, m_cv = 0, m_locked = 0;
    bit p_v = 0;
    int p_err = 0, p_integ = 0;

    always @(posedge clk) begin
        int e, s, t;
        bit old_shi, old_slo;
        if (rst) begin
            m_integ = 0; m_ctrl = 128; m_cnt = 0;
            m_shi = 0; m_slo = 0; m_cv = 0; m_locked = 0; p_v = 0;
        end else begin
            old_shi  = m_shi;
            old_slo  = m_slo;
            m_locked = (m_cnt == 16);
            if (p_v) begin
                s = 128 + fdiv(p_err, 2) + fdiv(p_integ, 16);
                m_shi  = (s > 255);
                m_slo  = (s < 0);
                m_ctrl = (s < 0) ? 0 : (s > 255) ? 255 : s;
                m_cv   = 1;
            end else begin
                m_cv = 0;
            end
            p_v = 0;
            if (err_valid && !hold) begin
                e = err;
                if (!((old_shi && e > 0) || (old_slo && e < 0))) begin
                    t = m_integ + e;
                    m_integ = (t > 32767) ? 32767 : (t < -32768) ? -32768 : t;
                end
                if (e <= 2 && e >= -2) m_cnt = (m_cnt < 16) ? m_cnt + 1 : 16;
                else m_cnt = 0;
                p_v = 1; p_err = e; p_integ = m_integ;
            end
        end
        #1;
        check("ctrl_out", ctrl_out, m_ctrl);
        check("ctrl_valid", ctrl_valid, m_cv);
        check("sat_hi", sat_hi, m_shi);
        check("sat_lo", sat_lo, m_slo);
        check("locked", locked, m_locked);
        if (ctrl_valid) cv_count++;
    end

    task automatic cyc(input bit v, input int e, input bit h);
        @(negedge clk);
        err_valid = v;
        err = 8'(e);
        hold = h;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; err_valid = 1'b0; hold = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int prev, snap;
        // Reset
        do_reset();
        check("rst_ctrl_out", ctrl_out, 128);
        check("rst_ctrl_valid", ctrl_valid, 0);
        check("rst_sat", {sat_hi, sat_lo}, 0);
        check("rst_locked", locked, 0);

        // Single samples
        cyc(1, 16, 0);
        check("lat_no_early", ctrl_valid, 0);
        cyc(0, 0, 0);
        check("single_pos", ctrl_out, 137);
        check("single_pos_v", ctrl_valid, 1);
        cyc(0, 0, 0);
        check("single_pulse_len", ctrl_valid, 0);
        cyc(1, -16, 0);
        cyc(0, 0, 0);
        check("single_neg", ctrl_out, 120);

        // Hold raised while a sample is in stage 1 does not cancel it
        cyc(1, 5, 0);
        cyc(1, 50, 1);
        check("hold_inflight", ctrl_valid, 1);
        cyc(0, 0, 0);

        // Lock
        for (int i = 0; i < 16; i++) cyc(1, 0, 0);
        check("lock_not_yet", locked, 0);
        cyc(0, 0, 0);
        check("lock_rise", locked, 1);
        snap = cv_count;
        for (int i = 0; i < 5; i++) cyc(1, 50, 1);
        check("hold_no_valid", cv_count - snap, 0);
        check("hold_keeps_lock", locked, 1);
        cyc(1, 50, 0);
        cyc(0, 0, 0);
        check("hold_release_v", ctrl_valid, 1);
        check("hold_release_unlock", locked, 0);
        for (int i = 0; i < 16; i++) cyc(1, 0, 0);
        cyc(1, 3, 0);
        check("relock", locked, 1);
        cyc(0, 0, 0);
        check("unlock_tol3", locked, 0);
        for (int i = 0; i < 15; i++) cyc(1, 0, 0);
        cyc(1, -128, 0);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        check("neg128_no_lock", locked, 0);

        // Reset discards in-flight sample
        cyc(1, 20, 0);
        do_reset();
        check("rst_flush_v", ctrl_valid, 0);
        check("rst_flush_out", ctrl_out, 128);
        cyc(0, 0, 0);
        check("rst_flush_v2", ctrl_valid, 0);

        // High saturation
        cyc(1, 127, 0);
        cyc(1, 127, 0);
        check("sat_first", ctrl_out, 198);
        prev = ctrl_out;
        for (int i = 0; i < 38; i++) begin
            cyc(1, 127, 0);
            check("sat_monotonic", int'(ctrl_out >= 8'(prev)), 1);
            prev = ctrl_out;
        end
        check("sat_hi_out", ctrl_out, 255);
        check("sat_hi_flag", sat_hi, 1);
        cyc(1, -127, 0);
        cyc(1, -127, 0);
        cyc(0, 0, 0);
        check("sat_hi_recover", int'(ctrl_out < 8'd255), 1);

        // Low saturation
        do_reset();
        for (int i = 0; i < 40; i++) cyc(1, -128, 0);
        check("sat_lo_out", ctrl_out, 0);
        check("sat_lo_flag", sat_lo, 1);
        for (int i = 0; i < 12; i++) cyc(1, 127, 0);
        cyc(0, 0, 0);
        check("sat_lo_recover", int'(ctrl_out > 8'd0), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
